// File: rtl/controlador_linha_envase_pkg.sv
// Shared definitions for the bottling line sequencer: state codes, default
// parameter values and the register widths derived from them.
package controlador_linha_envase_pkg;

    localparam int unsigned GARRAFAS_POR_DUZIA_DEF = 12;
    localparam int unsigned FILL_TIMEOUT_DEF       = 1000;
    localparam int unsigned CAP_CYCLES_DEF         = 50;
    localparam int unsigned MAX_ROLHAS_DEF         = 20;
    localparam int unsigned ROLHAS_INICIAIS_DEF    = 20;
    localparam int unsigned REFILL_ROLHAS_DEF      = 15;

    // One timer serves FILL and CAP, so it is sized for the longer of the two.
    localparam int unsigned TIMER_MAX  = (FILL_TIMEOUT_DEF > CAP_CYCLES_DEF) ?
                                         FILL_TIMEOUT_DEF : CAP_CYCLES_DEF;
    localparam int unsigned TIMER_W    = $clog2(TIMER_MAX);
    localparam int unsigned GARRAFAS_W = $clog2(GARRAFAS_POR_DUZIA_DEF);
    localparam int unsigned ROLHAS_W   = $clog2(MAX_ROLHAS_DEF + 1);
    localparam int unsigned ESTADO_W   = 3;

    typedef enum logic [ESTADO_W-1:0] {
        StIdle      = 3'd0,
        StTransport = 3'd1,
        StFill      = 3'd2,
        StCap       = 3'd3,
        StInspect   = 3'd4,
        StFault     = 3'd5
    } estado_e;

endpackage

// File: rtl/controlador_linha_envase_if.sv
// Operator/sensor/actuator bundle of the bottling line. The line controller
// takes the slave side; whatever drives sensors and buttons takes the master.
interface controlador_linha_envase_if;
    import controlador_linha_envase_pkg::*;

    logic                  start_i;
    logic                  stop_i;
    logic                  sensor_posicao_i;
    logic                  sensor_nivel_i;
    logic                  cq_valid_i;
    logic                  cq_ok_i;
    logic                  reabastecer_i;
    logic                  ack_alarme_i;

    logic                  motor_on_o;
    logic                  valvula_on_o;
    logic                  vedacao_on_o;
    logic                  descarte_o;
    logic                  incr_duzia_o;
    logic                  alarme_o;
    logic [ESTADO_W-1:0]   estado_o;
    logic [GARRAFAS_W-1:0] garrafas_o;
    logic [ROLHAS_W-1:0]   rolhas_o;

    modport master (
        output start_i, stop_i, sensor_posicao_i, sensor_nivel_i,
               cq_valid_i, cq_ok_i, reabastecer_i, ack_alarme_i,
        input  motor_on_o, valvula_on_o, vedacao_on_o, descarte_o,
               incr_duzia_o, alarme_o, estado_o, garrafas_o, rolhas_o
    );

    modport slave (
        input  start_i, stop_i, sensor_posicao_i, sensor_nivel_i,
               cq_valid_i, cq_ok_i, reabastecer_i, ack_alarme_i,
        output motor_on_o, valvula_on_o, vedacao_on_o, descarte_o,
               incr_duzia_o, alarme_o, estado_o, garrafas_o, rolhas_o
    );

endinterface

// File: rtl/controlador_linha_envase_detector_borda.sv
// Rising-edge detector: one register holds the previous sample, the pulse is
// high during the cycle in which the input is first seen high.
module controlador_linha_envase_detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic sinal_i,
    output logic pulso_o
);

    logic anterior_q;

    // Remember last cycle's level of the input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anterior_q <= 1'b0;
        end else begin
            anterior_q <= sinal_i;
        end
    end

    assign pulso_o = sinal_i & ~anterior_q;

endmodule

// File: rtl/controlador_linha_envase.sv
// Bottling line master sequencer: conveyor, fill, cap, inspection, approved
// bottle counting with a dozen pulse, cork stock and fault alarm.
module controlador_linha_envase
    import controlador_linha_envase_pkg::*;
#(
    parameter int unsigned GARRAFAS_POR_DUZIA = GARRAFAS_POR_DUZIA_DEF,
    parameter int unsigned FILL_TIMEOUT       = FILL_TIMEOUT_DEF,
    parameter int unsigned CAP_CYCLES         = CAP_CYCLES_DEF,
    parameter int unsigned MAX_ROLHAS         = MAX_ROLHAS_DEF,
    parameter int unsigned ROLHAS_INICIAIS    = ROLHAS_INICIAIS_DEF,
    parameter int unsigned REFILL_ROLHAS      = REFILL_ROLHAS_DEF
) (
    input logic                       clk,
    input logic                       reset,
    controlador_linha_envase_if.slave linha_io
);

    // Two spare bits so refill arithmetic cannot wrap before saturation.
    localparam int unsigned SomaW = ROLHAS_W + 2;

    logic start_p, stop_p, posicao_p, cq_p, reab_p, ack_p;

    controlador_linha_envase_detector_borda u_borda_start (
        .clk(clk), .reset(reset), .sinal_i(linha_io.start_i), .pulso_o(start_p)
    );
    controlador_linha_envase_detector_borda u_borda_stop (
        .clk(clk), .reset(reset), .sinal_i(linha_io.stop_i), .pulso_o(stop_p)
    );
    controlador_linha_envase_detector_borda u_borda_posicao (
        .clk(clk), .reset(reset), .sinal_i(linha_io.sensor_posicao_i), .pulso_o(posicao_p)
    );
    controlador_linha_envase_detector_borda u_borda_cq (
        .clk(clk), .reset(reset), .sinal_i(linha_io.cq_valid_i), .pulso_o(cq_p)
    );
    controlador_linha_envase_detector_borda u_borda_reab (
        .clk(clk), .reset(reset), .sinal_i(linha_io.reabastecer_i), .pulso_o(reab_p)
    );
    controlador_linha_envase_detector_borda u_borda_ack (
        .clk(clk), .reset(reset), .sinal_i(linha_io.ack_alarme_i), .pulso_o(ack_p)
    );

    estado_e               estado_q, estado_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [GARRAFAS_W-1:0] garrafas_q, garrafas_d;
    logic [ROLHAS_W-1:0]   rolhas_q, rolhas_d;
    logic                  stop_q, stop_d;
    logic                  descarte_q, descarte_d;
    logic                  incr_q, incr_d;
    logic                  motor_q, valvula_q, vedacao_q, alarme_q;
    logic                  consome_rolha;
    logic [SomaW-1:0]      soma_rolhas;

    // Next state, shared timer, bottle counter, stop latch and output pulses.
    always_comb begin
        estado_d      = estado_q;
        timer_d       = timer_q;
        garrafas_d    = garrafas_q;
        stop_d        = stop_q | stop_p;
        descarte_d    = 1'b0;
        incr_d        = 1'b0;
        consome_rolha = 1'b0;
        case (estado_q)
            StIdle: begin
                stop_d = 1'b0;
                // A simultaneous stop cancels the start.
                if (start_p && !stop_p) begin
                    estado_d = StTransport;
                end
            end
            StTransport: begin
                if (posicao_p) begin
                    estado_d = StFill;
                    timer_d  = '0;
                end
            end
            StFill: begin
                // Level reached takes priority over a timeout in the same cycle.
                if (linha_io.sensor_nivel_i) begin
                    if (rolhas_q != '0) begin
                        estado_d = StCap;
                        timer_d  = '0;
                    end else begin
                        estado_d = StFault;
                    end
                end else if (timer_q == TIMER_W'(FILL_TIMEOUT - 1)) begin
                    estado_d = StFault;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StCap: begin
                if (timer_q == TIMER_W'(CAP_CYCLES - 1)) begin
                    estado_d      = StInspect;
                    consome_rolha = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StInspect: begin
                if (cq_p) begin
                    if (linha_io.cq_ok_i) begin
                        if (garrafas_q == GARRAFAS_W'(GARRAFAS_POR_DUZIA - 1)) begin
                            garrafas_d = '0;
                            incr_d     = 1'b1;
                        end else begin
                            garrafas_d = garrafas_q + GARRAFAS_W'(1);
                        end
                    end else begin
                        descarte_d = 1'b1;
                    end
                    if (stop_q || stop_p) begin
                        estado_d = StIdle;
                        stop_d   = 1'b0;
                    end else begin
                        estado_d = StTransport;
                    end
                end
            end
            StFault: begin
                if (ack_p) begin
                    estado_d = StIdle;
                    stop_d   = 1'b0;
                end
            end
            default: begin
                estado_d = StIdle;
            end
        endcase
    end

    // Cork stock: consume one per capped bottle, add refills, saturate at the maximum.
    always_comb begin
        soma_rolhas = {2'b00, rolhas_q};
        if (consome_rolha) begin
            soma_rolhas = soma_rolhas - SomaW'(1);
        end
        if (reab_p) begin
            soma_rolhas = soma_rolhas + SomaW'(REFILL_ROLHAS);
        end
        if (soma_rolhas > SomaW'(MAX_ROLHAS)) begin
            soma_rolhas = SomaW'(MAX_ROLHAS);
        end
        rolhas_d = soma_rolhas[ROLHAS_W-1:0];
    end

    // State, counters and registered actuator outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= StIdle;
            timer_q    <= '0;
            garrafas_q <= '0;
            rolhas_q   <= ROLHAS_W'(ROLHAS_INICIAIS);
            stop_q     <= 1'b0;
            descarte_q <= 1'b0;
            incr_q     <= 1'b0;
            motor_q    <= 1'b0;
            valvula_q  <= 1'b0;
            vedacao_q  <= 1'b0;
            alarme_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            garrafas_q <= garrafas_d;
            rolhas_q   <= rolhas_d;
            stop_q     <= stop_d;
            descarte_q <= descarte_d;
            incr_q     <= incr_d;
            motor_q    <= (estado_d == StTransport) || (estado_d == StInspect);
            valvula_q  <= (estado_d == StFill);
            vedacao_q  <= (estado_d == StCap);
            alarme_q   <= (estado_d == StFault);
        end
    end

    assign linha_io.motor_on_o   = motor_q;
    assign linha_io.valvula_on_o = valvula_q;
    assign linha_io.vedacao_on_o = vedacao_q;
    assign linha_io.descarte_o   = descarte_q;
    assign linha_io.incr_duzia_o = incr_q;
    assign linha_io.alarme_o     = alarme_q;
    assign linha_io.estado_o     = estado_q;
    assign linha_io.garrafas_o   = garrafas_q;
    assign linha_io.rolhas_o     = rolhas_q;

endmodule

// File: tb/tb_controlador_linha_envase.sv
// Bench for the bottling line controller: random bottle traffic against a
// count/stock reference model, with a scoreboard checked at each bottle exit.
module tb_controlador_linha_envase;
    import controlador_linha_envase_pkg::*;

    localparam int InStart = 0, InStop = 1, InPosicao = 2, InCq = 3, InReab = 4, InAck = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controlador_linha_envase_if bus ();

    controlador_linha_envase dut (
        .clk      (clk),
        .reset    (reset),
        .linha_io (bus)
    );

    typedef struct {
        bit descarte;
        bit incr;
        int garrafas;
        int rolhas;
        int estado;
    } esperado_t;

    esperado_t fila[$];
    int  checks = 0;
    int  failures = 0;
    int  aprovadas_m;
    int  rolhas_m;
    bit  stop_m;

    task automatic check(input string nome, input int atual, input int req);
        checks++;
        if (atual != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, req, $time);
        end
    endtask

    function automatic int refill(input int r);
        return (r + REFILL_ROLHAS_DEF > MAX_ROLHAS_DEF) ? MAX_ROLHAS_DEF : r + REFILL_ROLHAS_DEF;
    endfunction

    task automatic set_in(input int qual, input logic v);
        case (qual)
            InStart:   bus.start_i = v;
            InStop:    bus.stop_i = v;
            InPosicao: bus.sensor_posicao_i = v;
            InCq:      bus.cq_valid_i = v;
            InReab:    bus.reabastecer_i = v;
            default:   bus.ack_alarme_i = v;
        endcase
    endtask

    // High for one cycle, then low for one so the next pulse is a fresh edge.
    task automatic pulso(input int qual);
        set_in(qual, 1'b1);
        @(negedge clk);
        set_in(qual, 1'b0);
        @(negedge clk);
    endtask

    task automatic esperar_estado(input int alvo, input int limite, input string nome);
        int n = 0;
        while (int'(bus.estado_o) != alvo && n < limite) begin
            @(negedge clk);
            n++;
        end
        check(nome, int'(bus.estado_o), alvo);
    endtask

    task automatic checar_reset(input string tag);
        check({tag, "_estado"}, int'(bus.estado_o), 0);
        check({tag, "_motor"}, int'(bus.motor_on_o), 0);
        check({tag, "_valvula"}, int'(bus.valvula_on_o), 0);
        check({tag, "_vedacao"}, int'(bus.vedacao_on_o), 0);
        check({tag, "_descarte"}, int'(bus.descarte_o), 0);
        check({tag, "_incr"}, int'(bus.incr_duzia_o), 0);
        check({tag, "_alarme"}, int'(bus.alarme_o), 0);
        check({tag, "_garrafas"}, int'(bus.garrafas_o), 0);
        check({tag, "_rolhas"}, int'(bus.rolhas_o), ROLHAS_INICIAIS_DEF);
    endtask

    // One bottle from TRANSPORT to the end of INSPECT (or FAULT on empty cork stock).
    task automatic run_bottle(input bit ok, input bit stop_fill, input bit refill_cap,
                              input int atraso);
        int n;
        esperado_t e;
        esperar_estado(1, 20, "estado_transporte");
        pulso(InPosicao);
        check("estado_fill", int'(bus.estado_o), 2);
        check("valvula_fill", int'(bus.valvula_on_o), 1);
        repeat (atraso) @(negedge clk);
        if (stop_fill) begin
            pulso(InStop);
            stop_m = 1'b1;
        end
        bus.sensor_nivel_i = 1'b1;
        @(negedge clk);
        bus.sensor_nivel_i = 1'b0;
        if (rolhas_m == 0) begin
            check("falta_rolha_estado", int'(bus.estado_o), 5);
            check("falta_rolha_alarme", int'(bus.alarme_o), 1);
            check("falta_rolha_valvula", int'(bus.valvula_on_o), 0);
            pulso(InAck);
            check("ack_idle", int'(bus.estado_o), 0);
            check("ack_alarme_off", int'(bus.alarme_o), 0);
            stop_m = 1'b0;
            return;
        end
        check("estado_cap", int'(bus.estado_o), 3);
        n = 0;
        while (int'(bus.estado_o) == 3 && n < 200) begin
            if (bus.vedacao_on_o) n++;
            // Refill edge lands on the same clock as the cork decrement.
            if (refill_cap && n == CAP_CYCLES_DEF) bus.reabastecer_i = 1'b1;
            @(negedge clk);
        end
        bus.reabastecer_i = 1'b0;
        check("ciclos_vedacao", n, CAP_CYCLES_DEF);
        rolhas_m = refill_cap ? refill(rolhas_m - 1) : rolhas_m - 1;
        check("estado_inspect", int'(bus.estado_o), 4);
        check("motor_inspect", int'(bus.motor_on_o), 1);
        if (ok) aprovadas_m++;
        e.descarte = !ok;
        e.incr     = ok && (aprovadas_m % GARRAFAS_POR_DUZIA_DEF == 0);
        e.garrafas = aprovadas_m % GARRAFAS_POR_DUZIA_DEF;
        e.rolhas   = rolhas_m;
        e.estado   = stop_m ? 0 : 1;
        fila.push_back(e);
        stop_m = 1'b0;
        bus.cq_ok_i = ok;
        pulso(InCq);
        bus.cq_ok_i = 1'b0;
    endtask

    // Scoreboard monitor: every exit from INSPECT is one bottle result.
    initial begin
        int  est_ant = 0;
        bit  pos_fim = 1'b0;
        esperado_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                est_ant = 0;
                pos_fim = 1'b0;
            end else begin
                if (pos_fim) begin
                    check("descarte_um_ciclo", int'(bus.descarte_o), 0);
                    check("incr_um_ciclo", int'(bus.incr_duzia_o), 0);
                    pos_fim = 1'b0;
                end
                if (est_ant == 4 && int'(bus.estado_o) != 4) begin
                    if (fila.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard: bottle finished with no expectation queued");
                    end else begin
                        e = fila.pop_front();
                        check("sb_descarte", int'(bus.descarte_o), int'(e.descarte));
                        check("sb_incr_duzia", int'(bus.incr_duzia_o), int'(e.incr));
                        check("sb_garrafas", int'(bus.garrafas_o), e.garrafas);
                        check("sb_rolhas", int'(bus.rolhas_o), e.rolhas);
                        check("sb_estado", int'(bus.estado_o), e.estado);
                    end
                    pos_fim = 1'b1;
                end
                est_ant = int'(bus.estado_o);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start_i = 0; bus.stop_i = 0; bus.sensor_posicao_i = 0; bus.sensor_nivel_i = 0;
        bus.cq_valid_i = 0; bus.cq_ok_i = 0; bus.reabastecer_i = 0; bus.ack_alarme_i = 0;
        aprovadas_m = 0;
        rolhas_m    = ROLHAS_INICIAIS_DEF;
        stop_m      = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        checar_reset("reset");
        reset = 1'b0;
        @(negedge clk);

        // Full dozen of approved bottles.
        pulso(InStart);
        check("start_transporte", int'(bus.estado_o), 1);
        for (int i = 0; i < 12; i++) run_bottle(1'b1, 1'b0, 1'b0, $urandom_range(0, 5));
        esperar_estado(1, 5, "duzia_fim");
        check("duzia_garrafas", int'(bus.garrafas_o), 0);
        check("duzia_rolhas", int'(bus.rolhas_o), 8);

        // Reject, then run the stock down to zero.
        run_bottle(1'b0, 1'b0, 1'b0, 2);
        while (rolhas_m > 0) run_bottle(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom_range(0, 8));
        run_bottle(1'b1, 1'b0, 1'b0, 1);

        // Refills: 0 -> 15, then 10 -> 20 saturated, then refill during cap at 20.
        pulso(InReab);
        rolhas_m = refill(rolhas_m);
        check("refill_de_zero", int'(bus.rolhas_o), rolhas_m);
        pulso(InStart);
        for (int i = 0; i < 5; i++) run_bottle(1'b1, 1'b0, 1'b0, 0);
        esperar_estado(1, 5, "pre_refill");
        check("rolhas_dez", int'(bus.rolhas_o), 10);
        pulso(InReab);
        rolhas_m = refill(rolhas_m);
        check("refill_saturado", int'(bus.rolhas_o), 20);
        run_bottle(1'b1, 1'b0, 1'b1, 0);

        // Fill timeout.
        esperar_estado(1, 5, "pre_timeout");
        bus.sensor_posicao_i = 1'b1;
        @(negedge clk);
        bus.sensor_posicao_i = 1'b0;
        n = 0;
        while (int'(bus.estado_o) == 2 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("timeout_ciclos_fill", n, FILL_TIMEOUT_DEF);
        check("timeout_estado", int'(bus.estado_o), 5);
        check("timeout_alarme", int'(bus.alarme_o), 1);
        check("timeout_valvula", int'(bus.valvula_on_o), 0);
        pulso(InAck);
        check("timeout_ack_idle", int'(bus.estado_o), 0);

        // Stop during FILL finishes the bottle, then IDLE.
        pulso(InStart);
        run_bottle(1'b1, 1'b1, 1'b0, 3);
        repeat (2) @(negedge clk);
        check("stop_idle", int'(bus.estado_o), 0);
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("start_stop_juntos", int'(bus.estado_o), 0);
        pulso(InStart);
        check("restart_transporte", int'(bus.estado_o), 1);

        // Random traffic.
        for (int i = 0; i < 20; i++) begin
            if (int'(bus.estado_o) == 0) begin
                if (rolhas_m == 0) begin
                    pulso(InReab);
                    rolhas_m = refill(rolhas_m);
                end
                pulso(InStart);
            end
            if ($urandom_range(0, 3) == 0) begin
                pulso(InReab);
                rolhas_m = refill(rolhas_m);
                check("refill_aleatorio", int'(bus.rolhas_o), rolhas_m);
            end
            run_bottle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 4) == 0), $urandom_range(0, 20));
            repeat (2) @(negedge clk);
        end

        // Reset asserted in the middle of CAP.
        if (int'(bus.estado_o) == 0) begin
            if (rolhas_m == 0) begin
                pulso(InReab);
                rolhas_m = refill(rolhas_m);
            end
            pulso(InStart);
        end
        if (rolhas_m == 0) begin
            pulso(InReab);
            rolhas_m = refill(rolhas_m);
        end
        esperar_estado(1, 5, "pre_reset_cap");
        pulso(InPosicao);
        bus.sensor_nivel_i = 1'b1;
        @(negedge clk);
        bus.sensor_nivel_i = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_vedacao", int'(bus.vedacao_on_o), 1);
        #1 reset = 1'b1;
        #1 checar_reset("reset_cap");
        aprovadas_m = 0;
        rolhas_m    = ROLHAS_INICIAIS_DEF;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("pos_reset_idle", int'(bus.estado_o), 0);

        check("fila_vazia", fila.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
